// File: rtl/fp_to_fixed.sv
// fp_to_fixed: three-stage pipelined float -> signed fixed-point converter.
// S1 classifies the float and computes the alignment shift, S2 builds the
// rounded magnitude, S3 applies sign and saturation and drives the outputs.
// The whole pipe advances together; a stalled output freezes every stage.
module fp_to_fixed #(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int O_WIDTH = 16,
  parameter int O_FRAC  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_DATA-1:0]  idata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [O_WIDTH-1:0] odata,
  output logic               o_sat,
  output logic               o_nan
);

  localparam int SW   = I_EXP + 2;          // signed shift width
  localparam int MW   = I_MNT + 1;          // mantissa with hidden one
  localparam int MAGW = O_WIDTH + 1;        // magnitude width (holds 2^(O_WIDTH-1))
  localparam int WW   = MW + MAGW;          // left-shift workspace
  localparam int LSW  = $clog2(O_WIDTH + 1);
  localparam int RSW  = $clog2(I_MNT + 2);
  localparam int BIAS = (1 << (I_EXP - 1)) - 1;

  localparam logic signed [SW-1:0] SHIFT_OFS = SW'(O_FRAC - I_MNT - BIAS);
  localparam logic signed [SW-1:0] SHIFT_MAX = SW'(O_WIDTH);
  localparam logic [SW-1:0]        RS_ZERO   = SW'(I_MNT + 2);
  localparam logic [MAGW-1:0]      POS_MAX   = MAGW'((1 << (O_WIDTH - 1)) - 1);
  localparam logic [MAGW-1:0]      NEG_LIM   = MAGW'(1 << (O_WIDTH - 1));
  localparam logic [O_WIDTH-1:0]   POS_CODE  = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic [O_WIDTH-1:0]   NEG_CODE  = {1'b1, {(O_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  logic adv;

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q,  s1_sign_d;
  cls_e                 s1_cls_q,   s1_cls_d;
  logic [MW-1:0]        s1_mant_q,  s1_mant_d;
  logic signed [SW-1:0] s1_shift_q, s1_shift_d;
  logic [I_EXP-1:0]     exp_v;
  logic [I_MNT-1:0]     man_v;

  // Stage 2 state
  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q,  s2_sign_d;
  cls_e                 s2_cls_q,   s2_cls_d;
  logic [MAGW-1:0]      s2_mag_q,   s2_mag_d;
  logic                 s2_ovf_q,   s2_ovf_d;
  logic [WW-1:0]        lsh_wide;
  logic [SW-1:0]        rs_full;
  logic [RSW-1:0]       rs;
  logic [MW-1:0]        rsh_q;
  logic [MW-1:0]        rnd_mask;
  logic                 guard_bit;
  logic                 rnd_up;
  logic [MW:0]          rnd_sum;

  // Stage 3 (output) state
  logic                 out_valid_q, out_valid_d;
  logic [O_WIDTH-1:0]   odata_q,     odata_d;
  logic                 o_sat_q,     o_sat_d;
  logic                 o_nan_q,     o_nan_d;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // S1: unpack the float, classify it and compute the signed alignment shift
  always_comb begin
    exp_v      = idata[I_DATA-2 -: I_EXP];
    man_v      = idata[I_MNT-1:0];
    s1_valid_d = in_valid;
    s1_sign_d  = idata[I_DATA-1];
    s1_mant_d  = {1'b1, man_v};
    s1_shift_d = $signed({2'b00, exp_v}) + SHIFT_OFS;
    if (exp_v == '0) begin
      s1_cls_d = CLS_ZERO;
    end else if (exp_v == '1) begin
      s1_cls_d = (man_v != '0) ? CLS_NAN : CLS_INF;
    end else begin
      s1_cls_d = CLS_NORM;
    end
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_mant_q  <= '0;
      s1_shift_q <= '0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_q   <= s1_cls_d;
      s1_mant_q  <= s1_mant_d;
      s1_shift_q <= s1_shift_d;
    end
  end

  // S2: align the mantissa; right shifts round half-to-even via guard and sticky
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_cls_d   = s1_cls_q;
    s2_mag_d   = '0;
    s2_ovf_d   = 1'b0;
    lsh_wide   = '0;
    rs_full    = '0;
    rs         = '0;
    rsh_q      = '0;
    rnd_mask   = '0;
    guard_bit  = 1'b0;
    rnd_up     = 1'b0;
    rnd_sum    = '0;
    if (!s1_shift_q[SW-1]) begin
      // Large left shifts can only overflow, so skip the shifter entirely.
      if (s1_shift_q > SHIFT_MAX) begin
        s2_ovf_d = 1'b1;
      end else begin
        lsh_wide = {{MAGW{1'b0}}, s1_mant_q} << s1_shift_q[LSW-1:0];
        s2_ovf_d = |lsh_wide[WW-1:MAGW];
        s2_mag_d = lsh_wide[MAGW-1:0];
      end
    end else begin
      rs_full = -s1_shift_q;
      // Beyond this distance the value is below half an LSB: result is zero.
      if (rs_full < RS_ZERO) begin
        rs        = rs_full[RSW-1:0];
        rsh_q     = s1_mant_q >> rs;
        guard_bit = s1_mant_q[rs - 1'b1];
        rnd_mask  = (MW'(1) << (rs - 1'b1)) - MW'(1);
        rnd_up    = guard_bit & ((|(s1_mant_q & rnd_mask)) | rsh_q[0]);
        rnd_sum   = {1'b0, rsh_q} + {{MW{1'b0}}, rnd_up};
        // Rounding carry-out participates in the overflow decision.
        s2_ovf_d  = |rnd_sum[MW:MAGW];
        s2_mag_d  = rnd_sum[MAGW-1:0];
      end
    end
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_cls_q   <= CLS_ZERO;
      s2_mag_q   <= '0;
      s2_ovf_q   <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_cls_q   <= s2_cls_d;
      s2_mag_q   <= s2_mag_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  // S3: apply sign, clamp to the signed range, and gate flags with valid
  always_comb begin
    out_valid_d = s2_valid_q;
    odata_d     = '0;
    o_sat_d     = 1'b0;
    o_nan_d     = 1'b0;
    if (s2_valid_q) begin
      case (s2_cls_q)
        CLS_NAN: begin
          o_nan_d = 1'b1;
        end
        CLS_INF: begin
          o_sat_d = 1'b1;
          odata_d = s2_sign_q ? NEG_CODE : POS_CODE;
        end
        CLS_ZERO: begin
          odata_d = '0;
        end
        default: begin
          if (!s2_sign_q && (s2_ovf_q || (s2_mag_q > POS_MAX))) begin
            o_sat_d = 1'b1;
            odata_d = POS_CODE;
          end else if (s2_sign_q && (s2_ovf_q || (s2_mag_q > NEG_LIM))) begin
            o_sat_d = 1'b1;
            odata_d = NEG_CODE;
          end else begin
            odata_d = s2_sign_q ? -s2_mag_q[O_WIDTH-1:0] : s2_mag_q[O_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  // S3 register, which is also the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      odata_q     <= '0;
      o_sat_q     <= 1'b0;
      o_nan_q     <= 1'b0;
    end else if (adv) begin
      out_valid_q <= out_valid_d;
      odata_q     <= odata_d;
      o_sat_q     <= o_sat_d;
      o_nan_q     <= o_nan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign odata     = odata_q;
  assign o_sat     = o_sat_q;
  assign o_nan     = o_nan_q;

endmodule

// File: tb/tb_fp_to_fixed.sv
// tb_fp_to_fixed: directed checks of the float -> Q4.12 converter.
module tb_fp_to_fixed;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] od;
    logic        sat;
    logic        nan;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] idata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] odata;
  logic        o_sat;
  logic        o_nan;

  int n_checks = 0;
  int n_fail   = 0;

  fp_to_fixed dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idata     (idata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .odata     (odata),
    .o_sat     (o_sat),
    .o_nan     (o_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Sends one float with out_ready held high and collects the result.
  // lat is the number of cycles from accept to out_valid, -1 on timeout.
  task automatic run_one(input logic [31:0] d, output logic [15:0] od,
                         output logic sat, output logic nan, output int lat);
    lat       = -1;
    od        = '0;
    sat       = 1'b0;
    nan       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    idata     = d;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid === 1'b1) begin
        lat = c;
        od  = odata;
        sat = o_sat;
        nan = o_nan;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    idata     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || odata !== 16'h0000 || o_sat !== 1'b0 || o_nan !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got out_valid=%b odata=%h sat=%b nan=%b want 0 0000 0 0",
               out_valid, odata, o_sat, o_nan);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1 (pipe empty, out_ready=0)", in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid got out_valid=%b want 0", out_valid);
    end
    $display("xfer reset: out_valid=%b odata=%h in_ready=%b", out_valid, odata, in_ready);
    out_ready = 1'b1;
  endtask

  task automatic test_basic();
    vec_t tv [2] = '{
      '{32'h3F800000, 16'h1000, 1'b0, 1'b0},
      '{32'hC0200000, 16'hD800, 1'b0, 1'b0}
    };
    logic [15:0] od;
    logic        sat;
    logic        nan;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_one(tv[i].d, od, sat, nan, lat);
      $display("xfer basic in=%h odata=%h sat=%b nan=%b lat=%0d", tv[i].d, od, sat, nan, lat);
      n_checks++;
      if (lat != 3) begin
        n_fail++;
        $display("FAIL basic_latency[%0d] got %0d cycles want 3", i, lat);
      end
      n_checks++;
      if (od !== tv[i].od || sat !== tv[i].sat || nan !== tv[i].nan) begin
        n_fail++;
        $display("FAIL basic[%0d] in=%h got odata=%h sat=%b nan=%b want odata=%h sat=%b nan=%b",
                 i, tv[i].d, od, sat, nan, tv[i].od, tv[i].sat, tv[i].nan);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t tv [6] = '{
      '{32'h42C80000, 16'h7FFF, 1'b1, 1'b0},   // 100.0
      '{32'hC1000000, 16'h8000, 1'b0, 1'b0},   // -8.0 exactly representable
      '{32'h41000000, 16'h7FFF, 1'b1, 1'b0},   // +8.0 one past max
      '{32'hFF800000, 16'h8000, 1'b1, 1'b0},   // -Inf
      '{32'h7F800000, 16'h7FFF, 1'b1, 1'b0},   // +Inf
      '{32'hC1000800, 16'h8000, 1'b1, 1'b0}    // just below -8.0
    };
    logic [15:0] od;
    logic        sat;
    logic        nan;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(tv[i].d, od, sat, nan, lat);
      $display("xfer sat in=%h odata=%h sat=%b nan=%b lat=%0d", tv[i].d, od, sat, nan, lat);
      n_checks++;
      if (lat != 3 || od !== tv[i].od || sat !== tv[i].sat || nan !== tv[i].nan) begin
        n_fail++;
        $display("FAIL saturation[%0d] in=%h got odata=%h sat=%b nan=%b lat=%0d want odata=%h sat=%b nan=%b lat=3",
                 i, tv[i].d, od, sat, nan, lat, tv[i].od, tv[i].sat, tv[i].nan);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t tv [5] = '{
      '{32'h39000000, 16'h0000, 1'b0, 1'b0},   // 0.5 LSB, tie to even 0
      '{32'h39C00000, 16'h0002, 1'b0, 1'b0},   // 1.5 LSB, tie to even 2
      '{32'h39400000, 16'h0001, 1'b0, 1'b0},   // 0.75 LSB, rounds up
      '{32'h3A200000, 16'h0002, 1'b0, 1'b0},   // 2.5 LSB, tie to even 2
      '{32'hB9C00000, 16'hFFFE, 1'b0, 1'b0}    // -1.5 LSB
    };
    logic [15:0] od;
    logic        sat;
    logic        nan;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_one(tv[i].d, od, sat, nan, lat);
      $display("xfer round in=%h odata=%h sat=%b nan=%b lat=%0d", tv[i].d, od, sat, nan, lat);
      n_checks++;
      if (lat != 3 || od !== tv[i].od || sat !== tv[i].sat || nan !== tv[i].nan) begin
        n_fail++;
        $display("FAIL rounding[%0d] in=%h got odata=%h sat=%b nan=%b lat=%0d want odata=%h sat=%b nan=%b lat=3",
                 i, tv[i].d, od, sat, nan, lat, tv[i].od, tv[i].sat, tv[i].nan);
      end
    end
  endtask

  task automatic test_specials();
    vec_t tv [5] = '{
      '{32'h7FC00000, 16'h0000, 1'b0, 1'b1},   // quiet NaN
      '{32'hFF800001, 16'h0000, 1'b0, 1'b1},   // negative NaN
      '{32'h00400000, 16'h0000, 1'b0, 1'b0},   // denormal flushed
      '{32'h80000000, 16'h0000, 1'b0, 1'b0},   // -0
      '{32'h33800000, 16'h0000, 1'b0, 1'b0}    // 2^-24
    };
    logic [15:0] od;
    logic        sat;
    logic        nan;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_one(tv[i].d, od, sat, nan, lat);
      $display("xfer special in=%h odata=%h sat=%b nan=%b lat=%0d", tv[i].d, od, sat, nan, lat);
      n_checks++;
      if (lat != 3 || od !== tv[i].od || sat !== tv[i].sat || nan !== tv[i].nan) begin
        n_fail++;
        $display("FAIL specials[%0d] in=%h got odata=%h sat=%b nan=%b lat=%0d want odata=%h sat=%b nan=%b lat=3",
                 i, tv[i].d, od, sat, nan, lat, tv[i].od, tv[i].sat, tv[i].nan);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [8] = '{32'h3F800000, 32'hC0200000, 32'h40000000, 32'hBF800000,
                             32'h3F000000, 32'h42C80000, 32'h00000000, 32'h3E800000};
    logic [15:0] vexp [8] = '{16'h1000, 16'hD800, 16'h2000, 16'hF000,
                              16'h0800, 16'h7FFF, 16'h0000, 16'h0400};
    int          sent;
    int          got;
    logic        acc;
    logic        stall_prev;
    logic        exp_rdy;
    logic [15:0] held;
    sent       = 0;
    got        = 0;
    acc        = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    @(posedge clk); #1;
    fork
      begin
        for (int t = 0; t < 40 && sent < 8; t++) begin
          in_valid = 1'b1;
          idata    = vin[sent];
          @(negedge clk);
          acc = in_ready;
          @(posedge clk); #1;
          if (acc) sent++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = !(c >= 5 && c < 9);
          @(negedge clk);
          exp_rdy = !(out_valid && !out_ready);
          n_checks++;
          if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, in_ready, exp_rdy);
          end
          if (stall_prev) begin
            n_checks++;
            if (out_valid !== 1'b1 || odata !== held) begin
              n_fail++;
              $display("FAIL b2b_hold cycle %0d got out_valid=%b odata=%h want 1 %h",
                       c, out_valid, odata, held);
            end
          end
          if (out_valid && out_ready) begin
            $display("xfer b2b out[%0d] odata=%h", got, odata);
            n_checks++;
            if (got >= 8) begin
              n_fail++;
              $display("FAIL b2b_extra cycle %0d got extra output %h want none", c, odata);
            end else if (odata !== vexp[got]) begin
              n_fail++;
              $display("FAIL b2b_data[%0d] got %h want %h", got, odata, vexp[got]);
            end
            got++;
          end
          stall_prev = out_valid && !out_ready;
          held       = odata;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n_checks++;
    if (got != 8 || sent != 8) begin
      n_fail++;
      $display("FAIL b2b_count got sent=%0d received=%0d want 8 8", sent, got);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] vin [3] = '{32'h42C80000, 32'h7FC00000, 32'h3F800000};
    logic [15:0] od;
    logic        sat;
    logic        nan;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      idata    = vin[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || odata !== 16'h7FFF || o_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_pre got out_valid=%b odata=%h sat=%b want 1 7fff 1",
               out_valid, odata, o_sat);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    $display("xfer reset_inflight: out_valid=%b odata=%h sat=%b nan=%b", out_valid, odata, o_sat, o_nan);
    n_checks++;
    if (out_valid !== 1'b0 || odata !== 16'h0000 || o_sat !== 1'b0 || o_nan !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset got out_valid=%b odata=%h sat=%b nan=%b want 0 0000 0 0",
               out_valid, odata, o_sat, o_nan);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_flushed cycle %0d got out_valid=%b odata=%h want 0", c, out_valid, odata);
      end
    end
    run_one(32'h40400000, od, sat, nan, lat);
    $display("xfer after_reset in=40400000 odata=%h sat=%b nan=%b lat=%0d", od, sat, nan, lat);
    n_checks++;
    if (lat != 3 || od !== 16'h3000 || sat !== 1'b0 || nan !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_after got odata=%h sat=%b nan=%b lat=%0d want 3000 0 0 3",
               od, sat, nan, lat);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    idata     = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
